// File: rtl/ir_fetch_unit.sv
// ir_fetch_unit: fetches 9-bit words from a synchronous ROM through a 2-deep prefetch FIFO into IR.
// A halt opcode stops fetching until reset.  Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module ir_fetch_unit #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned PC_RESET = 0,
   parameter logic [2:0]  HALT_OP  = 3'b111
) (
   input  logic              clk,
   input  logic              Resetn,
   input  logic              run,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [8:0]        mem_data,
   output logic [8:0]        ir,
   output logic              ir_valid,
   input  logic              done,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   logic [8:0] fifo0, fifo1;
   logic [1:0] count;
   logic       inflight;

   logic       free, take_fifo, take_bypass, load_any, hit_halt, push;
   logic [8:0] load_word, fifo0_n, fifo1_n;
   logic [1:0] count_n;

   // A read may issue only if FIFO slots cover every word already owed by the ROM.
   assign mem_rd   = Resetn & run & ~halted &
                     ((count == 2'd0) | ((count == 2'd1) & ~inflight));
   assign mem_addr = pc;

   always_comb begin
      free        = ~ir_valid | done;
      take_fifo   = free & (count != 2'd0);
      take_bypass = free & (count == 2'd0) & inflight;
      load_any    = take_fifo | take_bypass;
      load_word   = take_fifo ? fifo0 : mem_data;
      hit_halt    = load_any & (load_word[8:6] == HALT_OP);
      push        = inflight & ~take_bypass;

      fifo0_n = fifo0;
      fifo1_n = fifo1;
      count_n = count;
      if (take_fifo) begin
         fifo0_n = fifo1;
         count_n = count - 2'd1;
      end
      if (push) begin
         if (count_n == 2'd0) fifo0_n = mem_data;
         else                 fifo1_n = mem_data;
         count_n = count_n + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!Resetn) begin
         pc       <= ADDR_W'(PC_RESET);
         ir       <= '0;
         ir_valid <= 1'b0;
         halted   <= 1'b0;
         count    <= 2'd0;
         inflight <= 1'b0;
         fifo0    <= '0;
         fifo1    <= '0;
      end else begin
         inflight <= mem_rd;
         if (mem_rd) pc <= pc + ADDR_W'(1);
         // Once halted, late ROM returns are simply never consumed.
         if (!halted) begin
            if (hit_halt) begin
               halted   <= 1'b1;
               ir_valid <= 1'b0;
               count    <= 2'd0;
            end else begin
               fifo0 <= fifo0_n;
               fifo1 <= fifo1_n;
               count <= count_n;
               if (free) begin
                  ir_valid <= load_any;
                  if (load_any) ir <= load_word;
               end
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ir_fetch_unit.sv
// tb_ir_fetch_unit: directed scoreboard bench for ir_fetch_unit.
`timescale 1ns/1ps
`default_nettype none

module tb_ir_fetch_unit;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       Resetn = 1'b0, run = 1'b0, done = 1'b0;
   logic       mem_rd, ir_valid, halted;
   logic [7:0] mem_addr, pc;
   logic [8:0] mem_data = '0, ir;
   logic [8:0] rom [0:255];

   logic       rst2 = 1'b0, run2 = 1'b0, done2 = 1'b0;
   logic       mem_rd2, ir_valid2, halted2;
   logic [2:0] mem_addr2, pc2;
   logic [8:0] mem_data2 = '0, ir2;

   ir_fetch_unit dut (
      .clk(clk), .Resetn(Resetn), .run(run), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_data(mem_data), .ir(ir), .ir_valid(ir_valid), .done(done), .pc(pc), .halted(halted)
   );

   ir_fetch_unit #(.ADDR_W(3), .PC_RESET(6), .HALT_OP(3'b111)) dut2 (
      .clk(clk), .Resetn(rst2), .run(run2), .mem_rd(mem_rd2), .mem_addr(mem_addr2),
      .mem_data(mem_data2), .ir(ir2), .ir_valid(ir_valid2), .done(done2), .pc(pc2), .halted(halted2)
   );

   always @(posedge clk) if (mem_rd) mem_data <= rom[mem_addr];
   // Second ROM holds o1XY-style words whose low 3 bits echo the address.
   always @(posedge clk) if (mem_rd2) mem_data2 <= {6'o10, mem_addr2};

   int total = 0, bad = 0, pres_cnt = 0;
   logic [8:0] exp_ir [$];
   logic [2:0] exp_addr [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 'h%0h want 'h%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_rom(input logic [8:0] w0, w1, w2, w3, w4);
      for (int i = 0; i < 256; i++) rom[i] = 9'o000;
      rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3; rom[4] = w4;
   endtask

   // Two cycles of reset; returns at the start of cycle 0 with Resetn high.
   task automatic do_reset();
      Resetn = 1'b0;
      step();
      @(negedge clk);
      chk("rst_mem_rd",   32'(mem_rd),   0);
      chk("rst_pc",       32'(pc),       0);
      chk("rst_ir",       32'(ir),       0);
      chk("rst_ir_valid", 32'(ir_valid), 0);
      chk("rst_halted",   32'(halted),   0);
      step();
      Resetn = 1'b1;
   endtask

   // Scoreboard monitor: a new instruction is presented when ir_valid is high
   // and the previous cycle either had no valid IR or retired it.
   initial begin
      logic prev_v, prev_d, ovf;
      logic [8:0] e;
      prev_v = 1'b0;
      prev_d = 1'b0;
      forever begin
         @(negedge clk);
         if (!Resetn) begin
            prev_v = 1'b0;
            prev_d = 1'b0;
         end else begin
            ovf = !halted && dut.inflight && (dut.count == 2'd2) && ir_valid && !done;
            chk("fifo_room", 32'(ovf), 0);
            if (ir_valid && (!prev_v || prev_d)) begin
               pres_cnt++;
               if (exp_ir.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL ir_seq: got unexpected 'o%0o want none", ir);
               end else begin
                  e = exp_ir.pop_front();
                  chk("ir_seq", 32'(ir), 32'(e));
               end
            end
            prev_v = ir_valid;
            prev_d = done;
         end
      end
   end

   initial begin
      logic [2:0] a;
      forever begin
         @(negedge clk);
         if (rst2 && mem_rd2) begin
            if (exp_addr.size() == 0) begin
               total++;
               bad++;
               $display("FAIL wrap_addr: got unexpected read %0d want none", mem_addr2);
            end else begin
               a = exp_addr.pop_front();
               chk("wrap_addr", 32'(mem_addr2), 32'(a));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset / start-up latency and prefetch fill
      load_rom(9'o012, 9'o013, 9'o014, 9'o015, 9'o000);
      run = 1'b1; done = 1'b0;
      exp_ir.push_back(9'o012);
      do_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         case (c)
            0: begin chk("t1_rd0", 32'(mem_rd), 1); chk("t1_addr0", 32'(mem_addr), 0);
                     chk("t1_v0", 32'(ir_valid), 0); end
            1: begin chk("t1_v1", 32'(ir_valid), 0); chk("t1_pc1", 32'(pc), 1);
                     chk("t1_rd1", 32'(mem_rd), 1); end
            2: begin chk("t1_v2", 32'(ir_valid), 1); chk("t1_ir2", 32'(ir), 'o012);
                     chk("t1_pc2", 32'(pc), 2); chk("t1_rd2", 32'(mem_rd), 1); end
            3: begin chk("t1_pc3", 32'(pc), 3); chk("t1_rd3", 32'(mem_rd), 0); end
            default: begin chk("t1_rd_full", 32'(mem_rd), 0); chk("t1_pc_full", 32'(pc), 3); end
         endcase
         step();
      end
      chk("t1_sb_empty", 32'(exp_ir.size()), 0);

      // Back-to-back retire, ended by a halt word at address 4
      load_rom(9'o011, 9'o112, 9'o213, 9'o314, 9'o700);
      run = 1'b1; done = 1'b1;
      exp_ir.push_back(9'o011); exp_ir.push_back(9'o112);
      exp_ir.push_back(9'o213); exp_ir.push_back(9'o314);
      do_reset();
      pres_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         if (c == 6) chk("t2_no_gaps", 32'(pres_cnt), 4);
         @(negedge clk);
         if (c == 5) chk("t2_halt_pre", 32'(halted), 0);
         if (c == 6) begin
            chk("t2_halted", 32'(halted), 1); chk("t2_v", 32'(ir_valid), 0);
            chk("t2_rd", 32'(mem_rd), 0); chk("t2_pc", 32'(pc), 6);
         end
         step();
      end
      chk("t2_sb_empty", 32'(exp_ir.size()), 0);

      // Stall with done low, then one retire
      load_rom(9'o021, 9'o022, 9'o023, 9'o024, 9'o025);
      run = 1'b1; done = 1'b0;
      exp_ir.push_back(9'o021); exp_ir.push_back(9'o022);
      do_reset();
      for (int c = 0; c < 16; c++) begin
         done = (c == 12);
         @(negedge clk);
         if (c == 11) begin
            chk("t3_ir_hold", 32'(ir), 'o021); chk("t3_v_hold", 32'(ir_valid), 1);
            chk("t3_pc_hold", 32'(pc), 3); chk("t3_rd_hold", 32'(mem_rd), 0);
         end
         if (c == 13) begin
            chk("t3_ir_next", 32'(ir), 'o022); chk("t3_rd_refill", 32'(mem_rd), 1);
            chk("t3_addr_refill", 32'(mem_addr), 3);
         end
         if (c == 14) begin
            chk("t3_rd_once", 32'(mem_rd), 0); chk("t3_pc_after", 32'(pc), 4);
         end
         step();
      end
      done = 1'b0;
      chk("t3_sb_empty", 32'(exp_ir.size()), 0);

      // run dropped after the second read: both words retire, nothing more fetched
      load_rom(9'o031, 9'o032, 9'o033, 9'o034, 9'o035);
      run = 1'b1; done = 1'b0;
      exp_ir.push_back(9'o031); exp_ir.push_back(9'o032);
      do_reset();
      for (int c = 0; c < 9; c++) begin
         run  = (c < 2);
         done = (c >= 3);
         @(negedge clk);
         if (c >= 2) chk("t4_no_rd", 32'(mem_rd), 0);
         if (c == 2) chk("t4_ir_first", 32'(ir), 'o031);
         if (c == 8) begin
            chk("t4_pc", 32'(pc), 2); chk("t4_drained", 32'(ir_valid), 0);
         end
         step();
      end
      chk("t4_sb_empty", 32'(exp_ir.size()), 0);

      // Halt at address 2; the read issued alongside the halt selection still advances pc to 4
      load_rom(9'o041, 9'o042, 9'o700, 9'o043, 9'o044);
      run = 1'b1; done = 1'b1;
      exp_ir.push_back(9'o041); exp_ir.push_back(9'o042);
      do_reset();
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         if (c == 3) chk("t5_not_yet", 32'(halted), 0);
         if (c >= 4) begin
            chk("t5_halted", 32'(halted), 1); chk("t5_v", 32'(ir_valid), 0);
            chk("t5_rd", 32'(mem_rd), 0); chk("t5_pc", 32'(pc), 4);
         end
         step();
      end
      chk("t5_sb_empty", 32'(exp_ir.size()), 0);
      run = 1'b0; done = 1'b0;
      do_reset();
      @(negedge clk);
      chk("t5_cleared", 32'(halted), 0);
      chk("t5_idle_rd", 32'(mem_rd), 0);
      step();

      // PC wrap on the 3-bit instance starting at 6
      exp_addr.push_back(3'd6); exp_addr.push_back(3'd7);
      exp_addr.push_back(3'd0); exp_addr.push_back(3'd1);
      run2 = 1'b1; done2 = 1'b1;
      step();
      rst2 = 1'b1;
      for (int c = 0; c < 8; c++) begin
         run2 = (c < 4);
         @(negedge clk);
         case (c)
            2: chk("t6_ir6", 32'(ir2), 'o106);
            3: chk("t6_ir7", 32'(ir2), 'o107);
            4: chk("t6_ir0", 32'(ir2), 'o100);
            5: chk("t6_ir1", 32'(ir2), 'o101);
            6: chk("t6_drained", 32'(ir_valid2), 0);
            7: chk("t6_pc", 32'(pc2), 2);
            default: ;
         endcase
         step();
      end
      chk("t6_addr_empty", 32'(exp_addr.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
